// File: rtl/dispatch_pkg.sv
// Shared types and widths for the dispatch scheduler.
// DISPATCH_STATS_EN (see dispatch_scheduler) uses the stat widths below.
package dispatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FLUSH  = 2'd2
  } dispatch_state_t;

  localparam int unsigned STAT_DISPATCHED_W = 32;
  localparam int unsigned STAT_STALL_W      = 16;

  // Index width that stays at least one bit for single-element ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_port_alloc.sv
// In-order allocator: head entries go to ready ports scanned round-robin
// from rr_ptr; allocation stops when the free ports run out.
module rr_port_alloc
  import dispatch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MULTI_POP  = 3,
  parameter int unsigned NUM_PORTS  = 2
) (
  input  logic                                   enable,
  input  logic [MULTI_POP-1:0][DATA_WIDTH-1:0]   fifo_data,
  input  logic [$clog2(MULTI_POP):0]             ready_cnt,
  input  logic [NUM_PORTS-1:0]                   port_ready,
  input  logic [idx_width(NUM_PORTS)-1:0]        rr_ptr,
  output logic [NUM_PORTS-1:0]                   port_valid,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   port_data,
  output logic [$clog2(MULTI_POP):0]             pop_cnt,
  output logic [idx_width(NUM_PORTS)-1:0]        next_ptr
);

  localparam int unsigned CNT_W = $clog2(MULTI_POP) + 1;
  localparam int unsigned PTR_W = idx_width(NUM_PORTS);
  localparam int unsigned ENT_W = idx_width(MULTI_POP);

  int k;
  int last;
  int p;

  always_comb begin
    port_valid = '0;
    port_data  = '0;
    k          = 0;
    last       = 0;
    p          = 0;
    for (int j = 0; j < int'(NUM_PORTS); j++) begin
      p = int'(rr_ptr) + j;
      if (p >= int'(NUM_PORTS)) p = p - int'(NUM_PORTS);
      if (enable && port_ready[PTR_W'(p)] && (k < int'(ready_cnt)) && (k < int'(MULTI_POP))) begin
        port_valid[PTR_W'(p)] = 1'b1;
        port_data[PTR_W'(p)]  = fifo_data[ENT_W'(k)];
        k    = k + 1;
        last = p;
      end
    end
    pop_cnt  = CNT_W'(k);
    next_ptr = (k > 0) ? PTR_W'((last + 1) % int'(NUM_PORTS)) : rr_ptr;
  end

endmodule

// File: rtl/dispatch_scheduler.sv
// Dispatches FIFO head entries to consumer ports with halt/flush control.
// Define DISPATCH_STATS_EN to add the stat_dispatched/stat_stall counters.
module dispatch_scheduler
  import dispatch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MULTI_POP  = 3,
  parameter int unsigned NUM_PORTS  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [MULTI_POP-1:0][DATA_WIDTH-1:0] fifo_data,
  input  logic [$clog2(MULTI_POP):0]           fifo_ready_cnt,
  output logic [$clog2(MULTI_POP):0]           fifo_poll_cnt,
  output logic [NUM_PORTS-1:0]                 port_valid,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] port_data,
  input  logic [NUM_PORTS-1:0]                 port_ready,
  input  logic                                 halt,
  input  logic                                 flush,
  output logic                                 halted,
  output logic                                 flush_done
`ifdef DISPATCH_STATS_EN
  ,
  output logic [STAT_DISPATCHED_W-1:0]         stat_dispatched,
  output logic [STAT_STALL_W-1:0]              stat_stall
`endif
);

  localparam int unsigned PTR_W = idx_width(NUM_PORTS);
  localparam int unsigned CNT_W = $clog2(MULTI_POP) + 1;

  dispatch_state_t   state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  next_ptr;
  logic [CNT_W-1:0]  alloc_cnt;
  logic              dispatch_en;

  // halt/flush suppress dispatch in the same cycle they are raised
  assign dispatch_en = !rst && (state == ST_RUN) && !halt && !flush;

  rr_port_alloc #(
    .DATA_WIDTH (DATA_WIDTH),
    .MULTI_POP  (MULTI_POP),
    .NUM_PORTS  (NUM_PORTS)
  ) u_alloc (
    .enable     (dispatch_en),
    .fifo_data  (fifo_data),
    .ready_cnt  (fifo_ready_cnt),
    .port_ready (port_ready),
    .rr_ptr     (rr_ptr),
    .port_valid (port_valid),
    .port_data  (port_data),
    .pop_cnt    (alloc_cnt),
    .next_ptr   (next_ptr)
  );

  // Flushing drains whatever the FIFO reports, never more.
  always_comb begin
    fifo_poll_cnt = alloc_cnt;
    if (!rst && (state == ST_FLUSH)) fifo_poll_cnt = fifo_ready_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      rr_ptr     <= '0;
      halted     <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      halted     <= 1'b0;
      flush_done <= 1'b0;
      if (dispatch_en) rr_ptr <= next_ptr;
      if (flush) begin
        state <= ST_FLUSH;
      end else begin
        case (state)
          ST_RUN: begin
            if (halt) begin
              state  <= ST_HALTED;
              halted <= 1'b1;
            end
          end
          ST_HALTED: begin
            if (halt) halted <= 1'b1;
            else      state  <= ST_RUN;
          end
          ST_FLUSH: begin
            if (fifo_ready_cnt == '0) begin
              state      <= ST_RUN;
              flush_done <= 1'b1;
            end
          end
          default: state <= ST_RUN;
        endcase
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  // A stall is a RUN cycle with work pending but nothing dispatched.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_dispatched <= '0;
      stat_stall      <= '0;
    end else begin
      stat_dispatched <= stat_dispatched + STAT_DISPATCHED_W'(alloc_cnt);
      if ((state == ST_RUN) && (fifo_ready_cnt != '0) && (alloc_cnt == '0) &&
          (stat_stall != {STAT_STALL_W{1'b1}}))
        stat_stall <= stat_stall + STAT_STALL_W'(1);
    end
  end
`else
  // statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Self-checking bench for dispatch_scheduler: directed scenarios followed by
// randomized traffic against a queue-based FIFO and scheduler model.
module tb_dispatch_scheduler;

  localparam int DW = 8;
  localparam int MP = 3;
  localparam int NP = 2;
  localparam int CW = $clog2(MP) + 1;

  localparam int S_RUN   = 0;
  localparam int S_HALT  = 1;
  localparam int S_FLUSH = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [MP-1:0][DW-1:0]  fifo_data;
  logic [CW-1:0]          fifo_ready_cnt;
  logic [CW-1:0]          fifo_poll_cnt;
  logic [NP-1:0]          port_valid;
  logic [NP-1:0][DW-1:0]  port_data;
  logic [NP-1:0]          port_ready;
  logic                   halt;
  logic                   flush;
  logic                   halted;
  logic                   flush_done;
`ifdef DISPATCH_STATS_EN
  logic [31:0]            stat_dispatched;
  logic [15:0]            stat_stall;
`endif

  dispatch_scheduler #(.DATA_WIDTH(DW), .MULTI_POP(MP), .NUM_PORTS(NP)) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_data      (fifo_data),
    .fifo_ready_cnt (fifo_ready_cnt),
    .fifo_poll_cnt  (fifo_poll_cnt),
    .port_valid     (port_valid),
    .port_data      (port_data),
    .port_ready     (port_ready),
    .halt           (halt),
    .flush          (flush),
    .halted         (halted),
    .flush_done     (flush_done)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_dispatched(stat_dispatched),
    .stat_stall     (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int m_state = S_RUN;
  int m_ptr = 0;
  bit m_halted = 1'b0;
  bit m_flush_done = 1'b0;
  int unsigned m_disp = 0;
  int m_stall = 0;

  // expected combinational outputs for the current inputs
  int exp_poll;
  int exp_k;
  int exp_last;
  logic [NP-1:0]         exp_valid;
  logic [NP-1:0][DW-1:0] exp_data;

  logic [DW-1:0] fq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_comb();
    int free_ports[$];
    exp_valid = '0;
    exp_data  = '0;
    exp_poll  = 0;
    exp_k     = 0;
    exp_last  = 0;
    if (rst) return;
    if (m_state == S_FLUSH) begin
      exp_poll = int'(fifo_ready_cnt);
      return;
    end
    if (m_state != S_RUN || halt || flush) return;
    for (int j = 0; j < NP; j++) begin
      if (port_ready[(m_ptr + j) % NP]) free_ports.push_back((m_ptr + j) % NP);
    end
    exp_k = int'(fifo_ready_cnt);
    if (free_ports.size() < exp_k) exp_k = free_ports.size();
    if (MP < exp_k) exp_k = MP;
    for (int i = 0; i < exp_k; i++) begin
      exp_valid[free_ports[i]] = 1'b1;
      exp_data[free_ports[i]]  = fifo_data[i];
    end
    if (exp_k > 0) exp_last = free_ports[exp_k - 1];
    exp_poll = exp_k;
  endtask

  task automatic model_seq();
    if (rst) begin
      m_state = S_RUN; m_ptr = 0; m_halted = 1'b0; m_flush_done = 1'b0;
      m_disp = 0; m_stall = 0;
      return;
    end
    m_disp += exp_k;
    if (m_state == S_RUN && fifo_ready_cnt != 0 && exp_k == 0 && m_stall < 65535) m_stall++;
    m_flush_done = 1'b0;
    if (exp_k > 0) m_ptr = (exp_last + 1) % NP;
    if (flush) m_state = S_FLUSH;
    else if (m_state == S_RUN && halt) m_state = S_HALT;
    else if (m_state == S_HALT && !halt) m_state = S_RUN;
    else if (m_state == S_FLUSH && fifo_ready_cnt == 0) begin
      m_state = S_RUN;
      m_flush_done = 1'b1;
    end
    m_halted = (m_state == S_HALT);
  endtask

  // Check outputs for the inputs driven this cycle, then advance one clock.
  task automatic step(input string tag);
    #1;
    model_comb();
    chk({tag, "/poll"}, 32'(fifo_poll_cnt), 32'(exp_poll));
    chk({tag, "/overpop"}, 32'(fifo_poll_cnt <= fifo_ready_cnt), 32'd1);
    chk({tag, "/valid"}, 32'(port_valid), 32'(exp_valid));
    for (int p = 0; p < NP; p++)
      if (exp_valid[p]) chk({tag, "/data"}, 32'(port_data[p]), 32'(exp_data[p]));
    chk({tag, "/halted"}, 32'(halted), 32'(m_halted));
    chk({tag, "/flush_done"}, 32'(flush_done), 32'(m_flush_done));
`ifdef DISPATCH_STATS_EN
    chk({tag, "/stat_disp"}, stat_dispatched, 32'(m_disp));
    chk({tag, "/stat_stall"}, 32'(stat_stall), 32'(m_stall));
`endif
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic drive(input int rdy, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic [NP-1:0] pr);
    fifo_ready_cnt = CW'(rdy);
    fifo_data[0] = d0;
    fifo_data[1] = d1;
    fifo_data[2] = d2;
    port_ready = pr;
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; flush = 1'b0;
    drive(0, 8'h00, 8'h00, 8'h00, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state, even with work offered
    drive(2, 8'h11, 8'h22, 8'h33, 2'b11);
    #1;
    chk("reset/poll", 32'(fifo_poll_cnt), 32'd0);
    chk("reset/valid", 32'(port_valid), 32'd0);
    step("reset");
    rst = 1'b0;

    // two ports free, three entries: A->p0, B->p1
    drive(3, 8'hA1, 8'hB2, 8'hC3, 2'b11);
    #1;
    chk("inorder/poll", 32'(fifo_poll_cnt), 32'd2);
    chk("inorder/p0", 32'(port_data[0]), 32'hA1);
    chk("inorder/p1", 32'(port_data[1]), 32'hB2);
    step("inorder");

    // only port0 free: moves rr_ptr to 1
    drive(1, 8'hC3, 8'h00, 8'h00, 2'b01);
    step("ptr_to1");

    // rr_ptr=1: single entry lands on port1
    drive(1, 8'hD4, 8'h00, 8'h00, 2'b11);
    #1;
    chk("rr1/poll", 32'(fifo_poll_cnt), 32'd1);
    chk("rr1/valid", 32'(port_valid), 32'b10);
    chk("rr1/p1", 32'(port_data[1]), 32'hD4);
    step("rr1");

    // pointer wrapped back to 0
    drive(1, 8'hE5, 8'h00, 8'h00, 2'b11);
    #1;
    chk("rr0/valid", 32'(port_valid), 32'b01);
    step("rr0");

    // no free port: stall
    drive(2, 8'h01, 8'h02, 8'h00, 2'b00);
    #1;
    chk("stall/poll", 32'(fifo_poll_cnt), 32'd0);
    step("stall");

    // flush pulse, then drain 3,2,0
    flush = 1'b1;
    drive(3, 8'h01, 8'h02, 8'h03, 2'b11);
    step("flush_req");
    flush = 1'b0;
    step("flush3");
    drive(2, 8'h01, 8'h02, 8'h00, 2'b11);
    #1;
    chk("flush2/poll", 32'(fifo_poll_cnt), 32'd2);
    chk("flush2/valid", 32'(port_valid), 32'd0);
    step("flush2");
    drive(0, 8'h00, 8'h00, 8'h00, 2'b11);
    step("flush0");
    drive(1, 8'h77, 8'h00, 8'h00, 2'b11);
    #1;
    chk("flush_exit/done", 32'(flush_done), 32'd1);
    chk("flush_exit/poll", 32'(fifo_poll_cnt), 32'd1);
    step("flush_exit");
    chk("flush_done_pulse", 32'(flush_done), 32'd0);

    // halt: suppressed same cycle, halted next, resume cycle after release
    halt = 1'b1;
    drive(2, 8'h41, 8'h42, 8'h00, 2'b11);
    step("halt_req");
    chk("halt/halted", 32'(halted), 32'd1);
    step("halt_hold");
    halt = 1'b0;
    #1;
    chk("halt_rel/poll", 32'(fifo_poll_cnt), 32'd0);
    step("halt_rel");
    #1;
    chk("resume/poll", 32'(fifo_poll_cnt), 32'd2);
    step("resume");

    // reset in the middle of a flush
    flush = 1'b1;
    step("flush_req2");
    flush = 1'b0;
    step("in_flush");
    rst = 1'b1;
    step("rst_in_flush");
    rst = 1'b0;
    drive(0, 8'h00, 8'h00, 8'h00, 2'b11);
    #1;
    chk("post_rst/flush_done", 32'(flush_done), 32'd0);
    step("post_rst");
    drive(1, 8'h99, 8'h00, 8'h00, 2'b11);
    #1;
    chk("post_rst/valid", 32'(port_valid), 32'b01);
    step("post_rst_disp");

    // randomized traffic over a modelled FIFO
    fq.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      int rdy;
      rst   = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0) halt = ~halt;
      port_ready = NP'($urandom);
      if (fq.size() < 16) repeat ($urandom_range(0, 2)) fq.push_back(DW'($urandom));
      rdy = (fq.size() < MP) ? fq.size() : MP;
      fifo_ready_cnt = CW'(rdy);
      for (int i = 0; i < MP; i++) fifo_data[i] = (i < rdy) ? fq[i] : DW'($urandom);
      step("rand");
      repeat (exp_poll) if (fq.size() > 0) void'(fq.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dispatch_scheduler.md
DISPATCH_SCHEDULER -- requirements
Module: dispatch_scheduler

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_WIDTH, 8, entry width.
- MULTI_POP, 3, max entries poppable per cycle.
- NUM_PORTS, 2, consumer port count.
REQ-002 SHALL have ports, one per line:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- fifo_data  in  MULTI_POP x DATA_WIDTH  FIFO head entries, index 0 oldest.
- fifo_ready_cnt  in  $clog2(MULTI_POP)+1  valid head entries.
- fifo_poll_cnt  out  $clog2(MULTI_POP)+1  entries popped this cycle.
- port_valid  out  NUM_PORTS  entry offered to port.
- port_data  out  NUM_PORTS x DATA_WIDTH  entry payload per port.
- port_ready  in  NUM_PORTS  port can accept this cycle.
- halt  in  1  stop dispatch request.
- flush  in  1  discard FIFO contents request.
- halted  out  1  state == HALTED.
- flush_done  out  1  one-cycle pulse on FLUSH exit.

Function
REQ-003 SHALL implement FSM {RUN, HALTED, FLUSH}, one state register.
REQ-004 SHALL transition, flush highest priority: any state & flush -> FLUSH; RUN & halt -> HALTED; HALTED & !halt -> RUN; FLUSH & !flush & fifo_ready_cnt==0 -> RUN (flush_done=1 that cycle, registered).
REQ-005 SHALL dispatch only when state==RUN, halt==0, flush==0; otherwise port_valid=0.
REQ-006 SHALL allocate in order: entry i (i < fifo_ready_cnt) goes to the i-th port with port_ready=1, scanning ports from rr_ptr upward modulo NUM_PORTS.
REQ-007 SHALL stop at the first entry with no free port; later entries are never dispatched ahead of it.
REQ-008 SHALL drive fifo_poll_cnt = number of entries dispatched (k), combinationally, same cycle; k <= min(fifo_ready_cnt, NUM_PORTS, MULTI_POP).
REQ-009 SHALL assert port_valid only on ports receiving an entry; port_valid & port_ready = accepted (no retention).
REQ-010 SHALL advance rr_ptr by (index of last port used + 1) modulo NUM_PORTS when k>0; else hold.
REQ-011 SHALL, in FLUSH, drive fifo_poll_cnt = fifo_ready_cnt every cycle, port_valid=0.
REQ-012 SHALL never pop more than fifo_ready_cnt; fifo_ready_cnt==0 -> fifo_poll_cnt=0.
REQ-013 SHALL make halt effective same cycle (combinational suppression) and the state change next cycle.

Reset
REQ-014 SHALL on rst: state=RUN, rr_ptr=0, flush_done=0, halted=0; combinational outputs follow (port_valid=0, fifo_poll_cnt=0 while rst high).
REQ-015 SHALL abandon FLUSH/HALTED immediately on rst; no flush_done pulse.

Configuration
REQ-016 SHALL, with DISPATCH_STATS_EN defined, add outputs stat_dispatched (32b, += k per cycle) and stat_stall (16b saturating, +1 each RUN cycle with fifo_ready_cnt>0 and k==0), both cleared by rst; without it these ports and counters SHALL not exist.

Structure
REQ-017 SHALL place state enum dispatch_state_t and stat widths in package dispatch_pkg.
REQ-018 SHALL put the allocator (REQ-006/007) in combinational sub-module rr_port_alloc.

Verification (DATA_WIDTH=8, MULTI_POP=3, NUM_PORTS=2)
REQ-019 SHALL cover: ready_cnt=3, data {A,B,C}, port_ready=11, rr_ptr=0 -> port0=A, port1=B, poll_cnt=2, rr_ptr->0.
REQ-020 SHALL cover: rr_ptr=1, port_ready=11, ready_cnt=1 {D} -> port1=D, poll_cnt=1, rr_ptr->0.
REQ-021 SHALL cover: port_ready=00, ready_cnt=2 -> poll_cnt=0, port_valid=00, stat_stall +1 (stats build).
REQ-022 SHALL cover: flush 1 cycle with ready_cnt=3 then 2 then 0 -> poll_cnt 3,2,0; RUN and flush_done pulse after ready_cnt==0.
REQ-023 SHALL cover: halt high with ready_cnt=2 -> poll_cnt=0 same cycle, halted=1 next; halt low -> dispatch resumes cycle after.
REQ-024 SHALL cover: rst asserted mid-FLUSH -> next cycle state RUN, rr_ptr=0, flush_done=0; randomized compare against FIFO model with no over-pop.
